// File: rtl/vdc_vram_arbiter.sv
// vdc_vram_arbiter: fixed 8-dot VRAM slot scheduler sharing one VRAM port between BG fetch, sprite fetch and the CPU.
// Optional feature macro: VDC_SLOT_RECLAIM_EN (idle even slots are handed to a waiting CPU request).
module vdc_vram_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              dot_en,
   input  logic              line_start,
   input  logic              active_disp,
   input  logic              bg_req,
   input  logic              spr_req,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] bg_addr,
   input  logic [ADDR_W-1:0] spr_addr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_we,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              bg_gnt,
   output logic              spr_gnt,
   output logic              cpu_gnt,
   output logic              bg_rvalid,
   output logic              spr_rvalid,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              cpu_busy,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_BG   = 2'd1,
      OWN_SPR  = 2'd2,
      OWN_CPU  = 2'd3
   } owner_t;

   logic [2:0]        r_phase;
   logic [2:0]        w_phase_cur;
   owner_t            w_slot_owner;
   owner_t            w_win;
   owner_t            r_tag;
   logic              w_any_gnt;
   logic              w_cpu_write;
   logic [ADDR_W-1:0] w_addr;
   logic              r_bg_rvalid;
   logic              r_spr_rvalid;
   logic              r_cpu_rvalid;

   // A line_start on a dot cycle forces that very slot to phase 0.
   assign w_phase_cur = line_start ? 3'd0 : r_phase;

   always_comb begin
      w_slot_owner = w_phase_cur[0] ? OWN_CPU : (active_disp ? OWN_BG : OWN_SPR);
      w_win        = OWN_NONE;
      if (dot_en && !reset) begin
         case (w_slot_owner)
            OWN_BG:  if (bg_req)  w_win = OWN_BG;
            OWN_SPR: if (spr_req) w_win = OWN_SPR;
            OWN_CPU: if (cpu_req) w_win = OWN_CPU;
            default: w_win = OWN_NONE;
         endcase
`ifdef VDC_SLOT_RECLAIM_EN
         // Only an idle even slot can fall through here; odd slots already belong to the CPU.
         if (w_win == OWN_NONE && cpu_req) w_win = OWN_CPU;
`endif
      end
   end

   always_comb begin
      w_addr = '0;
      case (w_win)
         OWN_BG:  w_addr = bg_addr;
         OWN_SPR: w_addr = spr_addr;
         OWN_CPU: w_addr = cpu_addr;
         default: w_addr = '0;
      endcase
   end

   assign bg_gnt      = (w_win == OWN_BG);
   assign spr_gnt     = (w_win == OWN_SPR);
   assign cpu_gnt     = (w_win == OWN_CPU);
   assign w_any_gnt   = (w_win != OWN_NONE);
   assign w_cpu_write = cpu_gnt & cpu_we;
   assign cpu_busy    = cpu_req & ~cpu_gnt & ~reset;
   assign rdata       = mem_rdata;

   assign bg_rvalid   = r_bg_rvalid;
   assign spr_rvalid  = r_spr_rvalid;
   assign cpu_rvalid  = r_cpu_rvalid;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_phase      <= 3'd0;
         mem_en       <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         r_tag        <= OWN_NONE;
         r_bg_rvalid  <= 1'b0;
         r_spr_rvalid <= 1'b0;
         r_cpu_rvalid <= 1'b0;
      end else begin
         if (dot_en)
            r_phase <= w_phase_cur + 3'd1;
         else if (line_start)
            r_phase <= 3'd0;

         mem_en <= w_any_gnt;
         mem_we <= w_cpu_write;
         if (w_any_gnt) mem_addr  <= w_addr;
         if (cpu_gnt)   mem_wdata <= cpu_wdata;

         // Tag follows the access down the pipe so read data is steered to its owner at N+2.
         r_tag        <= (w_any_gnt && !w_cpu_write) ? w_win : OWN_NONE;
         r_bg_rvalid  <= (r_tag == OWN_BG);
         r_spr_rvalid <= (r_tag == OWN_SPR);
         r_cpu_rvalid <= (r_tag == OWN_CPU);
      end
   end

endmodule

// File: tb/tb_vdc_vram_arbiter.sv
// Self-checking bench for vdc_vram_arbiter: directed slot scenarios followed by randomized traffic.
module tb_vdc_vram_arbiter;
   localparam int AW = 16;
   localparam int DW = 16;

   logic          clock = 1'b0;
   logic          reset, dot_en, line_start, active_disp;
   logic          bg_req, spr_req, cpu_req, cpu_we;
   logic [AW-1:0] bg_addr, spr_addr, cpu_addr;
   logic [DW-1:0] cpu_wdata, mem_rdata;
   logic          bg_gnt, spr_gnt, cpu_gnt;
   logic          bg_rvalid, spr_rvalid, cpu_rvalid;
   logic [DW-1:0] rdata;
   logic          cpu_busy, mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;

   vdc_vram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clock(clock), .reset(reset), .dot_en(dot_en), .line_start(line_start),
      .active_disp(active_disp), .bg_req(bg_req), .spr_req(spr_req), .cpu_req(cpu_req),
      .bg_addr(bg_addr), .spr_addr(spr_addr), .cpu_addr(cpu_addr),
      .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
      .bg_gnt(bg_gnt), .spr_gnt(spr_gnt), .cpu_gnt(cpu_gnt),
      .bg_rvalid(bg_rvalid), .spr_rvalid(spr_rvalid), .cpu_rvalid(cpu_rvalid),
      .rdata(rdata), .cpu_busy(cpu_busy), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;

   // Reference model: slot counter as an integer, requester ids 0=none 1=bg 2=spr 3=cpu.
   int            m_phase = 0;
   int            m_rd1   = 0;   // read owner issued last cycle
   int            m_rv    = 0;   // owner whose rvalid is due now
   logic          m_en    = 1'b0;
   logic          m_we    = 1'b0;
   logic [AW-1:0] m_addr  = '0;
   logic [DW-1:0] m_wdata = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic rst, input logic de, input logic ls, input logic ad,
                       input logic br, input logic sr, input logic cr, input logic we);
      int cur;
      int win;
      reset = rst; dot_en = de; line_start = ls; active_disp = ad;
      bg_req = br; spr_req = sr; cpu_req = cr; cpu_we = we;
      #1;
      cur = ls ? 0 : m_phase;
      win = 0;
      if (de && !rst) begin
         if (cur % 2 == 1) win = cr ? 3 : 0;
         else if (ad && br) win = 1;
         else if (!ad && sr) win = 2;
`ifdef VDC_SLOT_RECLAIM_EN
         else if (cr) win = 3;
`endif
      end
      check("gnt", {29'd0, cpu_gnt, spr_gnt, bg_gnt}, {29'd0, win == 3, win == 2, win == 1});
      check("cpu_busy", {31'd0, cpu_busy}, {31'd0, cr && !rst && win != 3});
      check("mem_en", {31'd0, mem_en}, {31'd0, m_en});
      check("mem_we", {31'd0, mem_we}, {31'd0, m_we});
      check("mem_addr", {16'd0, mem_addr}, {16'd0, m_addr});
      check("mem_wdata", {16'd0, mem_wdata}, {16'd0, m_wdata});
      check("rvalid", {29'd0, cpu_rvalid, spr_rvalid, bg_rvalid}, {29'd0, m_rv == 3, m_rv == 2, m_rv == 1});
      if (m_rv != 0) check("rdata", {16'd0, rdata}, {16'd0, mem_rdata});
      $display("[TB] t=%0t rst=%0b de=%0b ls=%0b ad=%0b req=%0b%0b%0b phase=%0d win=%0d", $time,
               rst, de, ls, ad, br, sr, cr, cur, win);
      @(posedge clock);
      if (rst) begin
         m_phase = 0; m_rd1 = 0; m_rv = 0;
         m_en = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
      end else begin
         m_rv  = m_rd1;
         m_rd1 = (win != 0 && !(win == 3 && we)) ? win : 0;
         m_en  = (win != 0);
         m_we  = (win == 3) && we;
         if (win == 1) m_addr = bg_addr;
         if (win == 2) m_addr = spr_addr;
         if (win == 3) begin m_addr = cpu_addr; m_wdata = cpu_wdata; end
         if (de) m_phase = (cur + 1) % 8;
         else if (ls) m_phase = 0;
      end
      @(negedge clock);
   endtask

   initial begin
      bg_addr = 16'h0200; spr_addr = 16'h1234; cpu_addr = 16'h0100;
      cpu_wdata = 16'hA5A5; mem_rdata = 16'hBEEF;
      reset = 1'b1; dot_en = 1'b0; line_start = 1'b0; active_disp = 1'b1;
      bg_req = 1'b0; spr_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
      @(negedge clock);

      // Reset with every request high and dots running, then first grant is BG at phase 0.
      for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 1, 1, 1, 0);
      // BG and CPU held during active display: bg,cpu,bg,cpu...
      for (int i = 0; i < 8; i++) begin
         bg_addr = 16'h0200 + 16'(i);
         step(0, 1, 0, 1, 1, 0, 1, 0);
      end
      for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0, 0, 0, 0);
      // Sprite read during blanking.
      for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
      // Walk to phase 3 then issue a CPU write.
      for (int i = 0; i < 16 && m_phase != 3; i++) step(0, 1, 0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 1, 0, 0, 1, 1);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0, 0, 0, 0);
      // line_start at phase 5 forces phase 0, then phase 1 belongs to the CPU.
      for (int i = 0; i < 16 && m_phase != 5; i++) step(0, 1, 0, 1, 0, 0, 0, 0);
      step(0, 1, 1, 1, 1, 0, 1, 0);
      step(0, 1, 0, 1, 0, 0, 1, 0);
      // Lone CPU request at an even phase, held across stalled and live dots.
      for (int i = 0; i < 16 && m_phase != 2; i++) step(0, 1, 0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 1, 0);
      step(0, 1, 0, 1, 0, 0, 1, 0);
      step(0, 1, 0, 1, 0, 0, 1, 0);
      step(0, 1, 0, 1, 0, 0, 0, 0);
      // Reset mid-operation drops pending accesses.
      step(0, 1, 0, 1, 1, 0, 1, 0);
      step(1, 1, 0, 1, 1, 0, 1, 0);
      step(0, 1, 0, 1, 1, 0, 1, 0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         bg_addr   = 16'($urandom);
         spr_addr  = 16'($urandom);
         cpu_addr  = 16'($urandom);
         cpu_wdata = 16'($urandom);
         mem_rdata = 16'($urandom);
         step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 5,
              1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
